// File: rtl/muldiv_iter.sv
// Iterative RISC-V M-extension unit: one shift-add (multiply) or restoring-subtract (divide)
// step per clock, with bypass for divide-by-zero and signed overflow.
module muldiv_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_in,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_value_in,
    input  logic [XLEN-1:0] rs2_value_in,
    input  logic            kill_in,
    output logic            ready_out,
    output logic            valid_out,
    output logic [XLEN-1:0] result_out,
    output logic            non_zero_out
);

    localparam int unsigned CntW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e              state_q;
    logic [2:0]          op_q;
    logic                s1_q, s2_q;
    logic [CntW-1:0]     cnt_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN:0]       rem_q;
    logic [XLEN-1:0]     opnd_q;
    logic                byp_q;
    logic [XLEN-1:0]     byp_val_q;
    logic                valid_q;
    logic [XLEN-1:0]     result_q;

    // Operand decode at accept
    logic                is_div, sgn1, sgn2, s1, s2, ovf, byp;
    logic [XLEN-1:0]     mag1, mag2, byp_val;

    always_comb begin
        is_div  = funct3[2];
        sgn1    = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                  (funct3 == 3'b100) || (funct3 == 3'b110);
        sgn2    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        s1      = sgn1 & rs1_value_in[XLEN-1];
        s2      = sgn2 & rs2_value_in[XLEN-1];
        mag1    = s1 ? -rs1_value_in : rs1_value_in;
        mag2    = s2 ? -rs2_value_in : rs2_value_in;
        ovf     = !funct3[0] && (rs1_value_in == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2_value_in);
        byp     = is_div && ((rs2_value_in == '0) || ovf);
        byp_val = '0;
        if (rs2_value_in == '0) begin
            byp_val = funct3[1] ? rs1_value_in : '1;
        end else begin
            byp_val = funct3[1] ? '0 : rs1_value_in;
        end
    end

    // Per-cycle datapath steps and completion fix-up
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next;
    logic [XLEN:0]       div_shift;
    logic [XLEN+1:0]     div_trial;
    logic [2*XLEN-1:0]   div_acc_next;
    logic [XLEN:0]       div_rem_next;
    logic                neg;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quo, rmd, mul_res, div_res, final_res;

    always_comb begin
        mul_sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
        mul_next     = {mul_sum, acc_q[XLEN-1:1]};
        div_shift    = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
        div_trial    = {1'b0, div_shift} - {2'b0, opnd_q};
        div_acc_next = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], ~div_trial[XLEN+1]};
        div_rem_next = div_trial[XLEN+1] ? div_shift : div_trial[XLEN:0];

        // Remainder takes the dividend's sign; everything else the product of signs
        neg       = (op_q[2] && op_q[1]) ? s1_q : (s1_q ^ s2_q);
        prod      = neg ? -acc_q : acc_q;
        mul_res   = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        quo       = acc_q[XLEN-1:0];
        rmd       = rem_q[XLEN-1:0];
        div_res   = op_q[1] ? (neg ? -rmd : rmd) : (neg ? -quo : quo);
        final_res = byp_q ? byp_val_q : (op_q[2] ? div_res : mul_res);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            op_q      <= '0;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            opnd_q    <= '0;
            byp_q     <= 1'b0;
            byp_val_q <= '0;
            valid_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            valid_q <= 1'b0;
            if (kill_in) begin
                state_q <= StIdle;
            end else begin
                case (state_q)
                    StIdle, StDone: begin
                        if (start_in) begin
                            op_q      <= funct3;
                            s1_q      <= s1;
                            s2_q      <= s2;
                            cnt_q     <= CntW'(XLEN);
                            acc_q     <= {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
                            rem_q     <= '0;
                            opnd_q    <= is_div ? mag2 : mag1;
                            byp_q     <= byp;
                            byp_val_q <= byp_val;
                            state_q   <= StCalc;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                    StCalc: begin
                        if (byp_q || (cnt_q == '0)) begin
                            result_q <= final_res;
                            valid_q  <= 1'b1;
                            state_q  <= StDone;
                        end else begin
                            cnt_q <= cnt_q - CntW'(1);
                            if (op_q[2]) begin
                                acc_q <= div_acc_next;
                                rem_q <= div_rem_next;
                            end else begin
                                acc_q <= mul_next;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign ready_out    = (state_q != StCalc);
    assign valid_out    = valid_q;
    assign result_out   = result_q;
    assign non_zero_out = |result_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: directed table, hand-written corner sequences and
// randomized operations against an arithmetic reference model.
module tb_muldiv_iter;

    localparam int unsigned XLEN = 32;
    localparam int          Lat  = XLEN + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_in = 1'b0;
    logic [2:0]        funct3 = '0;
    logic [XLEN-1:0]   rs1 = '0;
    logic [XLEN-1:0]   rs2 = '0;
    logic              kill_in = 1'b0;
    logic              ready_out, valid_out, non_zero_out;
    logic [XLEN-1:0]   result_out;

    int                checks = 0;
    int                failures = 0;
    logic [XLEN-1:0]   last_res = '0;

    muldiv_iter #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_in     (start_in),
        .funct3       (funct3),
        .rs1_value_in (rs1),
        .rs2_value_in (rs2),
        .kill_in      (kill_in),
        .ready_out    (ready_out),
        .valid_out    (valid_out),
        .result_out   (result_out),
        .non_zero_out (non_zero_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        int          si, sj;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        si = $signed(a);
        sj = $signed(b);
        case (f)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return si / sj;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return si % sj;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return Lat;
    endfunction

    // Present a request for one edge, then scramble the operand inputs
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        funct3   = f;
        rs1      = a;
        rs2      = b;
        start_in = 1'b1;
        @(posedge clk);
        #1;
        start_in = 1'b0;
        funct3   = 3'($urandom);
        rs1      = $urandom;
        rs2      = $urandom;
    endtask

    task automatic wait_valid(output int n, output logic busy_ok);
        n = 0;
        busy_ok = 1'b1;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (valid_out) return;
            if (ready_out) busy_ok = 1'b0;
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int   n;
        logic busy_ok;
        issue(f, a, b);
        wait_valid(n, busy_ok);
        check({name, "_lat"}, 64'(n), 64'(lat));
        check({name, "_busy"}, 64'(busy_ok), 64'(1));
        check({name, "_res"}, 64'(result_out), 64'(exp));
        check({name, "_nz"}, 64'(non_zero_out), 64'(exp != 0));
        check({name, "_ready_done"}, 64'(ready_out), 64'(1));
        last_res = exp;
    endtask

    task automatic watch_no_valid(input string name, input int cycles);
        logic seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (valid_out) seen = 1'b1;
        end
        check(name, 64'(seen), 64'(0));
    endtask

    initial begin
        int          n;
        logic [2:0]  f;
        logic [31:0] a, b;

        vecs[0]  = '{"mulh",    3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, Lat};
        vecs[1]  = '{"mulhu",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, Lat};
        vecs[2]  = '{"mulhsu",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, Lat};
        vecs[3]  = '{"div",     3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, Lat};
        vecs[4]  = '{"rem",     3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, Lat};
        vecs[5]  = '{"divu",    3'd5, 32'd100,       32'd7,         32'd14,        Lat};
        vecs[6]  = '{"remu",    3'd7, 32'd100,       32'd7,         32'd2,         Lat};
        vecs[7]  = '{"div0",    3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[8]  = '{"remu0",   3'd7, 32'd5,         32'd0,         32'd5,         1};
        vecs[9]  = '{"div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[10] = '{"rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1};
        vecs[11] = '{"divu0",   3'd5, 32'd9,         32'd0,         32'hFFFF_FFFF, 1};

        // Reset state
        #12;
        check("rst_ready", 64'(ready_out), 64'(1));
        check("rst_valid", 64'(valid_out), 64'(0));
        check("rst_result", 64'(result_out), 64'(0));
        check("rst_nz", 64'(non_zero_out), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // MUL with single-cycle valid pulse
        run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, Lat);
        @(posedge clk);
        #1;
        check("mul_valid_once", 64'(valid_out), 64'(0));
        check("mul_ready_after", 64'(ready_out), 64'(1));

        // Directed table, each issued in the previous op's DONE cycle
        foreach (vecs[i]) run_op(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp,
                                 vecs[i].lat);
        @(posedge clk);
        #1;

        // Kill on the 10th CALC edge of a MUL
        issue(3'd0, 32'd3, 32'd5);
        repeat (9) @(posedge clk);
        #1;
        kill_in = 1'b1;
        @(posedge clk);
        #1;
        kill_in = 1'b0;
        check("kill_valid", 64'(valid_out), 64'(0));
        check("kill_ready", 64'(ready_out), 64'(1));
        check("kill_result", 64'(result_out), 64'(last_res));
        watch_no_valid("kill_no_valid", 40);

        // start together with kill in IDLE is not accepted
        funct3   = 3'd0;
        rs1      = 32'd3;
        rs2      = 32'd5;
        start_in = 1'b1;
        kill_in  = 1'b1;
        @(posedge clk);
        #1;
        start_in = 1'b0;
        kill_in  = 1'b0;
        check("startkill_ready", 64'(ready_out), 64'(1));
        watch_no_valid("startkill_no_valid", 40);
        check("startkill_result", 64'(result_out), 64'(last_res));

        // start during CALC is ignored
        issue(3'd5, 32'd100, 32'd7);
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 3) begin
                start_in = 1'b1;
                funct3   = 3'd0;
                rs1      = 32'hDEAD_BEEF;
                rs2      = 32'h1234_5678;
            end
            if (n == 6) start_in = 1'b0;
            if (valid_out) break;
        end
        check("busy_start_lat", 64'(n), 64'(Lat));
        check("busy_start_res", 64'(result_out), 64'(14));
        last_res = 32'd14;

        // Randomized operations against the reference model, back to back
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: a = $urandom_range(0, 50);
                2: b = $urandom_range(1, 9);
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4: b = -($urandom_range(1, 9));
                default: ;
            endcase
            run_op($sformatf("rnd%0d_f%0d", i, f), f, a, b, ref_model(f, a, b), ref_lat(f, a, b));
        end
        @(posedge clk);
        #1;

        // Reset asserted mid-DIV
        issue(3'd4, 32'hFFFF_FFF9, 32'd2);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 64'(ready_out), 64'(1));
        check("midrst_valid", 64'(valid_out), 64'(0));
        check("midrst_result", 64'(result_out), 64'(0));
        check("midrst_nz", 64'(non_zero_out), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        watch_no_valid("midrst_no_valid", 40);
        check("midrst_result_after", 64'(result_out), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
